// File: rtl/pio_in_irq_deb.sv
// pio_in_irq_deb: Avalon-MM input PIO with sync, debounce, edge capture and masked IRQ; PIO_IN_RAW_READ_EN exposes raw sync at address 1
module pio_in_irq_deb #(
  parameter int WIDTH = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync, filtered, prev, edge_det, edge_capture, irq_mask, clr;
  logic [31:0] raw, rdata_nxt;
  logic wr, unused;
  assign unused = ^writedata;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
    assign filtered = sync;
  end else begin : g_deb
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic filt;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          cnt <= '0;
          filt <= 1'b0;
        end else if (sync[i] == filt) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt <= sync[i];
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
      assign filtered[i] = filt;
    end
  end
  assign edge_det = EDGE_TYPE == 0 ? filtered & ~prev :
                    EDGE_TYPE == 1 ? ~filtered & prev : filtered ^ prev;
  assign wr = chipselect && !write_n;
  assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
`ifdef PIO_IN_RAW_READ_EN
  assign raw = 32'(sync);
`else
  assign raw = '0;
`endif
  always_comb
    rdata_nxt = address == 2'd0 ? 32'(filtered) :
                address == 2'd1 ? raw :
                address == 2'd2 ? 32'(irq_mask) : 32'(edge_capture);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= '0;
      edge_capture <= '0;
      irq_mask <= '0;
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      prev <= filtered;
      edge_capture <= (edge_capture & ~clr) | edge_det;
      if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      readdata <= rdata_nxt;
      irq <= |(edge_capture & irq_mask);
    end
endmodule

// File: tb/tb_pio_in_irq_deb.sv
// tb_pio_in_irq_deb: three PIO configurations checked against a history-window reference model
module tb_pio_in_irq_deb;
  localparam int SSP [3] = '{2, 2, 3};
  localparam int DBP [3] = '{0, 4, 0};
  localparam int ETP [3] = '{0, 2, 1};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] address = 2'd0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [5:0] ip [3];
  logic [31:0] rd [3];
  logic irq_w [3];
  int checks = 0;
  int failures = 0;
  logic [5:0] mh [3][16];
  logic [5:0] mf [3], mp [3], mcap [3], mmask [3];
  logic [31:0] mrd [3];
  logic mirq [3];
  always #5 clk = ~clk;
  pio_in_irq_deb #(.WIDTH(6), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(ip[0]), .readdata(rd[0]), .irq(irq_w[0]));
  pio_in_irq_deb #(.WIDTH(6), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(ip[1]), .readdata(rd[1]), .irq(irq_w[1]));
  pio_in_irq_deb #(.WIDTH(6), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) u_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(ip[2]), .readdata(rd[2]), .irq(irq_w[2]));
  task automatic chk(input string tag, input int k, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, o, e);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mf[k] = 0; mp[k] = 0; mcap[k] = 0; mmask[k] = 0; mrd[k] = 0; mirq[k] = 0;
      for (int j = 0; j < 16; j++) mh[k][j] = 0;
    end
  endtask
  // mh[k][n] is the in_port value sampled n+1 edges ago; sync seen at this edge is mh[k][SS-1]
  task automatic model_edge();
    logic [5:0] s, f, e, clr, all;
    logic [31:0] raw;
    for (int k = 0; k < 3; k++) begin
      s = mh[k][SSP[k]-1];
      f = DBP[k] == 0 ? s : mf[k];
      e = ETP[k] == 0 ? f & ~mp[k] : ETP[k] == 1 ? ~f & mp[k] : f ^ mp[k];
`ifdef PIO_IN_RAW_READ_EN
      raw = {26'd0, s};
`else
      raw = 32'd0;
`endif
      mrd[k] = address == 0 ? {26'd0, f} : address == 1 ? raw :
               address == 2 ? {26'd0, mmask[k]} : {26'd0, mcap[k]};
      mirq[k] = |(mcap[k] & mmask[k]);
      clr = (chipselect && !write_n && address == 3) ? writedata[5:0] : 6'd0;
      mcap[k] = (mcap[k] & ~clr) | e;
      if (chipselect && !write_n && address == 2) mmask[k] = writedata[5:0];
      mp[k] = f;
      if (DBP[k] > 0) begin
        all = 6'h3F;
        for (int j = 0; j < DBP[k]; j++) all &= mh[k][SSP[k]-1+j] ^ mf[k];
        mf[k] ^= all;
      end
      for (int j = 15; j > 0; j--) mh[k][j] = mh[k][j-1];
      mh[k][0] = ip[k];
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset(); else model_edge();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rd", k, rd[k], mrd[k]);
      chk("irq", k, {31'd0, irq_w[k]}, {31'd0, mirq[k]});
    end
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom();
  endtask
  initial begin
    for (int k = 0; k < 3; k++) ip[k] = 6'd0;
    model_reset();
    step(); step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_rd", k, rd[k], 32'd0);
      chk("rst_irq", k, {31'd0, irq_w[k]}, 32'd0);
    end
    reset_n = 1'b1;
    bus_wr(2, 32'hFFFF_FF3F);
    address = 2; step();
    chk("mask_rd", 0, rd[0], 32'h3F);
    address = 3; ip[0] = 6'h05;
    step(); step(); step();
    chk("irq_t2", 0, {31'd0, irq_w[0]}, 32'd0);
    step();
    chk("cap_t3", 0, rd[0], 32'h5);
    chk("irq_t3", 0, {31'd0, irq_w[0]}, 32'd1);
    bus_wr(3, 32'h1); step();
    chk("w1c_1", 0, rd[0], 32'h4);
    chk("w1c_1_irq", 0, {31'd0, irq_w[0]}, 32'd1);
    bus_wr(3, 32'h4); step();
    chk("w1c_4", 0, rd[0], 32'h0);
    chk("w1c_4_irq", 0, {31'd0, irq_w[0]}, 32'd0);
    ip[0] = 6'h01; repeat (4) step();
    chk("no_fall_cap", 0, rd[0], 32'h0);
    ip[0] = 6'h05; step(); step();
    bus_wr(3, 32'h4); address = 3; step();
    chk("set_wins", 0, rd[0], 32'h4);
    chk("set_wins_irq", 0, {31'd0, irq_w[0]}, 32'd1);
    bus_wr(2, 32'h0); address = 3; step();
    chk("masked_irq", 0, {31'd0, irq_w[0]}, 32'd0);
    chk("masked_keep", 0, rd[0], 32'h4);
    bus_wr(2, 32'h4); address = 3; step();
    chk("unmask_irq", 0, {31'd0, irq_w[0]}, 32'd1);
    bus_wr(3, 32'h3F); address = 0;
    ip[1] = 6'h01; repeat (3) step(); ip[1] = 6'h00;
    repeat (8) begin
      step();
      chk("glitch_filt", 1, rd[1], 32'h0);
    end
    address = 3; step();
    chk("glitch_cap", 1, rd[1], 32'h0);
    address = 0; ip[1] = 6'h01;
    repeat (6) step();
    chk("deb_t5", 1, rd[1], 32'h0);
    step();
    chk("deb_t6", 1, rd[1], 32'h1);
    address = 3; step();
    chk("deb_cap_rise", 1, rd[1], 32'h1);
    bus_wr(3, 32'h1); address = 3; step();
    chk("deb_clr", 1, rd[1], 32'h0);
    ip[1] = 6'h00; repeat (8) step();
    chk("deb_cap_fall", 1, rd[1], 32'h1);
    bus_wr(3, 32'h3F); address = 3;
    ip[2] = 6'h01; repeat (6) step();
    chk("fall_only_rise", 2, rd[2], 32'h0);
    ip[2] = 6'h00; repeat (6) step();
    chk("fall_only_fall", 2, rd[2], 32'h1);
    address = 1; ip[0] = 6'h2A;
    step(); step(); step();
`ifdef PIO_IN_RAW_READ_EN
    chk("raw_rd", 0, rd[0], 32'h2A);
`else
    chk("raw_rd", 0, rd[0], 32'h0);
`endif
    repeat (400) begin
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 6; b++)
          if ($urandom_range(0, k == 1 ? 15 : 7) == 0) ip[k][b] = ~ip[k][b];
      address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) bus_wr(2'($urandom_range(0, 3)), $urandom());
      else step();
    end
    bus_wr(2, 32'h3F);
    ip[0] = 6'h00; repeat (3) step();
    ip[0] = 6'h3F; ip[1] = ~ip[1];
    repeat (4) step();
    reset_n = 1'b0; model_reset(); #1;
    for (int k = 0; k < 3; k++) begin
      chk("async_rd", k, rd[k], 32'd0);
      chk("async_irq", k, {31'd0, irq_w[k]}, 32'd0);
    end
    for (int k = 0; k < 3; k++) ip[k] = 6'd0;
    step(); step();
    reset_n = 1'b1;
    address = 2; step();
    for (int k = 0; k < 3; k++) chk("post_rst_mask", k, rd[k], 32'd0);
    address = 3; step();
    for (int k = 0; k < 3; k++) chk("post_rst_cap", k, rd[k], 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
